pi_stream: RTL

Row-serial, parametrised implementation of the cyclical column permutation Pi over an N×4 byte matrix (4 ≤ N ≤ 10). A matrix enters one 32-bit row per beat over a valid/ready handshake and leaves one permuted row per beat. A two-bank ping-pong buffer sustains one row per cycle. It sits in the round datapath between the row-serial nonlinear layer and the column-mixing stage, and supports forward Pi and, optionally, inverse Pi per matrix.

---
 rtl/pi_pkg.sv | 27 ++
 rtl/pi_stream_bank.sv | 57 +++++
 rtl/pi_stream.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pi_pkg.sv
// Shared types, limits and index helper for the row-serial Pi column permutation.
package pi_pkg;

    localparam int unsigned PI_ROWS_MIN = 4;
    localparam int unsigned PI_ROWS_MAX = 10;
    localparam int unsigned PI_COLS     = 4;
    localparam int unsigned PI_BYTE_W   = 8;

    // Element [PI_COLS-1] is column 0 (the most significant byte).
    typedef logic [PI_COLS-1:0][PI_BYTE_W-1:0] pi_row_t;

    // Source row feeding output (row, col); col < rows, so one correction step is enough.
    function automatic int unsigned pi_src_row(input int unsigned row, input int unsigned col,
                                               input logic inv, input int unsigned rows);
        int unsigned idx;
        if (inv) begin
            idx = row + col;
            if (idx >= rows) idx = idx - rows;
        end else if (row >= col) begin
            idx = row - col;
        end else begin
            idx = row + rows - col;
        end
        return idx;
    endfunction

endpackage

// File: rtl/pi_stream_bank.sv
// One ROWS-deep row store with full flag; the mode bit exists only with PI_STREAM_INVERSE_EN.
module pi_stream_bank
    import pi_pkg::*;
#(
    parameter int unsigned ROWS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_addr,
    input  pi_row_t                 wr_data,
    input  logic                    set_full,
    input  logic                    clr_full,
`ifdef PI_STREAM_INVERSE_EN
    input  logic                    wr_inv,
    output logic                    mode,
`endif
    output logic                    full,
    output pi_row_t                 rows [ROWS]
);

    pi_row_t mem_q [ROWS];
    logic    full_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else if (set_full) begin
            full_q <= 1'b1;
        end else if (clr_full) begin
            full_q <= 1'b0;
        end
    end

`ifdef PI_STREAM_INVERSE_EN
    logic mode_q;

    // Mode is captured with row 0 and applies to the whole matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (wr_en && (wr_addr == '0)) begin
            mode_q <= wr_inv;
        end
    end

    assign mode = mode_q;
`endif

    assign full = full_q;
    assign rows = mem_q;

endmodule

// File: rtl/pi_stream.sv
// Row-serial Pi column permutation with a ping-pong bank pair.
// Inverse Pi is available when PI_STREAM_INVERSE_EN is defined.
module pi_stream
    import pi_pkg::*;
#(
    parameter int unsigned ROWS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_row,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_row,
    output logic        out_last
);

    localparam int unsigned   CW   = $clog2(ROWS);
    localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

    if ((ROWS < PI_ROWS_MIN) || (ROWS > PI_ROWS_MAX)) begin : g_rows_check
        $error("pi_stream: ROWS must be within 4..10");
    end

    logic          wbank_q, wbank_d, rbank_q, rbank_d;
    logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic          in_fire, out_fire, wr_last, rd_last;
    logic          full0, full1, rd_mode;
    pi_row_t       rows0 [ROWS];
    pi_row_t       rows1 [ROWS];
    pi_row_t       row_mux;
    int unsigned   src_idx;
    logic [CW-1:0] src_sel;

    assign in_ready  = wbank_q ? !full1 : !full0;
    assign out_valid = rbank_q ? full1 : full0;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign wr_last   = (wcnt_q == LAST);
    assign rd_last   = (rcnt_q == LAST);

`ifdef PI_STREAM_INVERSE_EN
    logic mode0, mode1;
    assign rd_mode = rbank_q ? mode1 : mode0;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign rd_mode       = 1'b0;
`endif

    pi_stream_bank #(
        .ROWS(ROWS)
    ) u_bank0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (in_fire && !wbank_q),
        .wr_addr  (wcnt_q),
        .wr_data  (in_row),
        .set_full (in_fire && !wbank_q && wr_last),
        .clr_full (out_fire && !rbank_q && rd_last),
`ifdef PI_STREAM_INVERSE_EN
        .wr_inv   (in_inv),
        .mode     (mode0),
`endif
        .full     (full0),
        .rows     (rows0)
    );

    pi_stream_bank #(
        .ROWS(ROWS)
    ) u_bank1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (in_fire && wbank_q),
        .wr_addr  (wcnt_q),
        .wr_data  (in_row),
        .set_full (in_fire && wbank_q && wr_last),
        .clr_full (out_fire && rbank_q && rd_last),
`ifdef PI_STREAM_INVERSE_EN
        .wr_inv   (in_inv),
        .mode     (mode1),
`endif
        .full     (full1),
        .rows     (rows1)
    );

    always_comb begin
        wcnt_d  = wcnt_q;
        wbank_d = wbank_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;
        if (in_fire) begin
            if (wr_last) begin
                wcnt_d  = '0;
                wbank_d = !wbank_q;
            end else begin
                wcnt_d = wcnt_q + CW'(1);
            end
        end
        if (out_fire) begin
            if (rd_last) begin
                rcnt_d  = '0;
                rbank_d = !rbank_q;
            end else begin
                rcnt_d = rcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q  <= '0;
            wbank_q <= 1'b0;
            rcnt_q  <= '0;
            rbank_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            wbank_q <= wbank_d;
            rcnt_q  <= rcnt_d;
            rbank_q <= rbank_d;
        end
    end

    // Each output column reads its own, diagonally offset row of the draining bank.
    always_comb begin
        row_mux = '0;
        src_idx = '0;
        src_sel = '0;
        for (int j = 0; j < PI_COLS; j++) begin
            src_idx = pi_src_row(32'(rcnt_q), unsigned'(j), rd_mode, ROWS);
            src_sel = CW'(src_idx);
            row_mux[PI_COLS-1-j] = rbank_q ? rows1[src_sel][PI_COLS-1-j]
                                           : rows0[src_sel][PI_COLS-1-j];
        end
        if (!out_valid) row_mux = '0;
    end

    assign out_row  = row_mux;
    assign out_last = out_valid && rd_last;

endmodule
